term_decoder: RTL and testbench
===============================

Name: term_decoder

Overview:
- Terminal-side receiver for the byte stream our serial link carries: plain text plus ANSI/VT100 CSI escape sequences (ESC [ ...).
- Takes bytes from the UART RX byte interface and maintains a cursor.
- Drives the write port of the 10-bit-addressed text buffer, so received text and cursor commands land in screen memory.
- Counterpart of the refresh/cursor sender on the other end of the link.

Parameters:
- COLS, 40, columns per row.
- ROWS, 25, rows per screen. COLS*ROWS must be at most 1024.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_byte  in  8  received byte.
- i_byte_v  in  1  one-cycle strobe, i_byte valid.
- o_wen  out  1  text buffer write enable, one-cycle pulse.
- o_addr  out  10  text buffer address.
- o_wdata  out  8  text buffer write data.
- o_cursor  out  10  current cursor address, row*COLS+col.
- o_busy  out  1  high while a screen clear runs.
- o_overrun  out  1  one-cycle pulse when a byte is dropped during busy.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0, all outputs are 0, row=col=0, state=GROUND and params are 0. Reset mid-clear abandons the clear.
- Internal state: row (5b) and col (6b) registers; o_cursor = row*COLS+col, registered and updated the cycle after any change.
- State machine: GROUND, ESC, CSI, CLEAR. Each byte is processed in the cycle its i_byte_v is high.
- GROUND, printable 0x20..0x7E:
  - Next cycle: o_wen=1, o_addr=old cursor address, o_wdata=byte.
  - Then col+1. At col=COLS-1, col stays (see optional feature).
- GROUND, control bytes:
  - 0x0D (CR): col=0.
  - 0x0A (LF): row+1, clamped at ROWS-1 (no scroll).
  - 0x08 (BS): col-1, clamped at 0.
  - 0x1B: go to ESC.
  - All other bytes (<0x20, 0x7F, >=0x80): ignored.
- ESC state:
  - '[' clears p0, p1 and param index, then goes to CSI.
  - 0x1B stays in ESC.
  - Any other byte is discarded and returns to GROUND.
- CSI state, parameter bytes:
  - Digit '0'..'9': p[idx] = p[idx]*10 + digit, saturating at 255 (8-bit).
  - ';': idx=1. A further ';' is ignored.
  - 0x1B: go to ESC.
- CSI state, final bytes (parameter value 0 means 1 where a count is used):
  - 'A': row -= p0, clamp 0.
  - 'B': row += p0, clamp ROWS-1.
  - 'C': col += p0, clamp COLS-1.
  - 'D': col -= p0, clamp 0.
  - 'H' or 'f': row = min(max(p0,1)-1, ROWS-1); col = min(max(p1,1)-1, COLS-1).
  - 'J' with p0==2: enter CLEAR. Any other p0 is ignored.
  - Any other byte aborts to GROUND and is discarded. After a final byte, return to GROUND.
- Arithmetic: intermediate sums at least 9 bits wide, so clamping never wraps.
- CLEAR state:
  - o_busy=1.
  - Writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, o_wen held high.
  - After the last write: row=col=0, o_busy=0, return to GROUND.
  - Takes exactly COLS*ROWS cycles.
  - Any i_byte_v during CLEAR is dropped and o_overrun pulses the next cycle.
- o_wen is never high outside a printable write or CLEAR.

Optional Feature:
- Macro: TERM_DECODER_AUTOWRAP_EN.
- Defined: a printable written at col=COLS-1 moves the cursor to col 0 of row+1. On the last row the cursor stays at the final cell.
- Undefined: col stays at COLS-1, and subsequent printables overwrite that cell.

Test Plan:
- Reset, then bytes "Hi" -> writes (addr 0, 0x48) and (addr 1, 0x69); o_cursor=2.
- "ESC[5;10H" then 'X' -> write at addr 4*40+9=169; o_cursor=170.
- "ESC[99A", "ESC[300B", "ESC[0C" from cursor 0 -> row clamps to 0, row to 24, col to 1; o_cursor=961.
- "ESC[2J" -> o_busy high exactly 1000 cycles with sequential writes of 0x20 to 0..999. A byte injected mid-clear gives an o_overrun pulse and no write. Afterwards o_cursor=0.
- 41 printables on row 0 -> with macro: 41st written at addr 40, o_cursor=41; without: last writes land at addr 39, o_cursor=39.
- "ESC[3x", then "ESCQ", then CR/LF/BS sequence from col 5 -> aborts produce no writes. CR gives col 0, LF gives row+1, BS at col 0 stays at 0. rst_n low mid-sequence returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/term_decoder.sv
// term_decoder: terminal-side receiver for a text + ANSI/VT100 CSI byte stream.
// Keeps a row/col cursor and drives the write port of a 10-bit-addressed text
// buffer so that printable bytes and cursor commands land in screen memory.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_byte     received byte
//   i_byte_v   one-cycle strobe, i_byte valid
//   o_wen      text buffer write enable (one-cycle pulse, held during clear)
//   o_addr     text buffer address
//   o_wdata    text buffer write data
//   o_cursor   cursor address row*COLS+col, one cycle behind row/col
//   o_busy     high while a screen clear runs
//   o_overrun  one-cycle pulse when a byte is dropped during a clear
//
// Build option: define TERM_DECODER_AUTOWRAP_EN to wrap the cursor to the next
// row after a printable written in the last column.
module term_decoder #(
    parameter int unsigned COLS = 40,
    parameter int unsigned ROWS = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_v,
    output logic       o_wen,
    output logic [9:0] o_addr,
    output logic [7:0] o_wdata,
    output logic [9:0] o_cursor,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam logic [4:0] ROW_MAX   = 5'(ROWS - 1);
    localparam logic [5:0] COL_MAX   = 6'(COLS - 1);
    localparam logic [8:0] ROW_MAX9  = 9'(ROWS - 1);
    localparam logic [8:0] COL_MAX9  = 9'(COLS - 1);
    localparam logic [9:0] LAST_CELL = 10'(COLS * ROWS - 1);

    typedef enum logic [1:0] {GROUND, ESC, CSI, CLEAR} state_t;

    state_t     state;
    logic [4:0] row;
    logic [5:0] col;
    logic [7:0] p0;
    logic [7:0] p1;
    logic       idx;
    logic [9:0] clr_addr;

    logic [9:0]  cur_addr;
    logic [7:0]  p_cur;
    logic [11:0] p_acc;
    logic [7:0]  p_new;
    logic [7:0]  cnt;
    logic [8:0]  cnt9;
    logic [8:0]  row_up9;
    logic [8:0]  col_up9;
    logic [4:0]  row_up;
    logic [4:0]  row_dn;
    logic [5:0]  col_up;
    logic [5:0]  col_dn;
    logic [7:0]  hr;
    logic [7:0]  hc;
    logic [4:0]  row_abs;
    logic [5:0]  col_abs;
    logic        is_print;
    logic        is_digit;

    assign cur_addr = 10'(row) * 10'(COLS) + 10'(col);
    assign is_print = (i_byte >= 8'h20) && (i_byte <= 8'h7E);
    assign is_digit = (i_byte >= 8'h30) && (i_byte <= 8'h39);

    // Parameter accumulation and cursor arithmetic, all clamped in >= 9 bits.
    always_comb begin
        p_cur   = idx ? p1 : p0;
        p_acc   = 12'(p_cur) * 12'd10 + 12'(i_byte - 8'h30);
        p_new   = (p_acc > 12'd255) ? 8'hFF : p_acc[7:0];

        cnt     = (p0 == 8'd0) ? 8'd1 : p0;
        cnt9    = 9'(cnt);
        row_up9 = 9'(row) + cnt9;
        col_up9 = 9'(col) + cnt9;
        row_up  = (row_up9 > ROW_MAX9) ? ROW_MAX : row_up9[4:0];
        col_up  = (col_up9 > COL_MAX9) ? COL_MAX : col_up9[5:0];
        row_dn  = (cnt9 > 9'(row)) ? 5'd0 : row - cnt[4:0];
        col_dn  = (cnt9 > 9'(col)) ? 6'd0 : col - cnt[5:0];

        hr      = (p0 == 8'd0) ? 8'd0 : p0 - 8'd1;
        hc      = (p1 == 8'd0) ? 8'd0 : p1 - 8'd1;
        row_abs = (9'(hr) > ROW_MAX9) ? ROW_MAX : hr[4:0];
        col_abs = (9'(hc) > COL_MAX9) ? COL_MAX : hc[5:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GROUND;
            row       <= '0;
            col       <= '0;
            p0        <= '0;
            p1        <= '0;
            idx       <= 1'b0;
            clr_addr  <= '0;
            o_wen     <= 1'b0;
            o_addr    <= '0;
            o_wdata   <= '0;
            o_cursor  <= '0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_wen     <= 1'b0;
            o_overrun <= 1'b0;
            o_cursor  <= cur_addr;

            case (state)
                GROUND: begin
                    if (i_byte_v) begin
                        if (is_print) begin
                            o_wen   <= 1'b1;
                            o_addr  <= cur_addr;
                            o_wdata <= i_byte;
                            if (col != COL_MAX) begin
                                col <= col + 6'd1;
                            end
`ifdef TERM_DECODER_AUTOWRAP_EN
                            else if (row != ROW_MAX) begin
                                col <= '0;
                                row <= row + 5'd1;
                            end
`endif
                        end else begin
                            case (i_byte)
                                8'h0D: col <= '0;
                                8'h0A: if (row != ROW_MAX) row <= row + 5'd1;
                                8'h08: if (col != 6'd0) col <= col - 6'd1;
                                8'h1B: state <= ESC;
                                default: ;
                            endcase
                        end
                    end
                end

                ESC: begin
                    if (i_byte_v) begin
                        if (i_byte == 8'h5B) begin
                            p0    <= '0;
                            p1    <= '0;
                            idx   <= 1'b0;
                            state <= CSI;
                        end else if (i_byte != 8'h1B) begin
                            state <= GROUND;
                        end
                    end
                end

                CSI: begin
                    if (i_byte_v) begin
                        // Finals and unknown bytes both land in GROUND.
                        state <= GROUND;
                        if (is_digit) begin
                            state <= CSI;
                            if (idx) p1 <= p_new;
                            else     p0 <= p_new;
                        end else if (i_byte == 8'h3B) begin
                            state <= CSI;
                            idx   <= 1'b1;
                        end else if (i_byte == 8'h1B) begin
                            state <= ESC;
                        end else begin
                            case (i_byte)
                                8'h41: row <= row_dn;
                                8'h42: row <= row_up;
                                8'h43: col <= col_up;
                                8'h44: col <= col_dn;
                                8'h48, 8'h66: begin
                                    row <= row_abs;
                                    col <= col_abs;
                                end
                                8'h4A: begin
                                    if (p0 == 8'd2) begin
                                        state    <= CLEAR;
                                        o_busy   <= 1'b1;
                                        clr_addr <= '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                CLEAR: begin
                    o_overrun <= i_byte_v;
                    o_wen     <= 1'b1;
                    o_addr    <= clr_addr;
                    o_wdata   <= 8'h20;
                    if (clr_addr == LAST_CELL) begin
                        state  <= GROUND;
                        o_busy <= 1'b0;
                        row    <= '0;
                        col    <= '0;
                    end else begin
                        clr_addr <= clr_addr + 10'd1;
                    end
                end

                default: state <= GROUND;
            endcase
        end
    end

endmodule

// File: tb/tb_term_decoder.sv
// Testbench for term_decoder: scoreboard of expected buffer writes fed by a
// behavioural terminal model, a monitor that pops on every o_wen, plus
// directed and randomized byte streams.
module tb_term_decoder;

    localparam int COLS  = 40;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       i_byte_v = 1'b0;
    logic       o_wen;
    logic [9:0] o_addr;
    logic [7:0] o_wdata;
    logic [9:0] o_cursor;
    logic       o_busy;
    logic       o_overrun;

    term_decoder #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_byte    (i_byte),
        .i_byte_v  (i_byte_v),
        .o_wen     (o_wen),
        .o_addr    (o_addr),
        .o_wdata   (o_wdata),
        .o_cursor  (o_cursor),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  ovr_seen = 0;
    int  busy_cycles = 0;

    // Terminal model: mode 0 = text, 1 = after ESC, 2 = inside CSI.
    int m_row, m_col, m_mode, m_idx;
    int m_p[2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Monitor: every write the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_busy) busy_cycles++;
            if (o_overrun) ovr_seen++;
            if (o_wen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", o_addr, o_wdata);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("write_addr", int'(o_addr), w.addr);
                    check("write_data", int'(o_wdata), w.data);
                end
            end
        end
    end

    task automatic model_reset();
        m_row = 0; m_col = 0; m_mode = 0; m_idx = 0;
        m_p[0] = 0; m_p[1] = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit clr);
        int bi;
        int n;
        bi  = int'(b);
        clr = 1'b0;
        if (m_mode == 0) begin
            if (bi >= 32 && bi <= 126) begin
                exp_q.push_back('{m_row * COLS + m_col, bi});
                if (m_col < COLS - 1) m_col++;
`ifdef TERM_DECODER_AUTOWRAP_EN
                else if (m_row < ROWS - 1) begin
                    m_col = 0;
                    m_row++;
                end
`endif
            end else if (bi == 13) m_col = 0;
            else if (bi == 10) m_row = imin(m_row + 1, ROWS - 1);
            else if (bi == 8)  m_col = imax(m_col - 1, 0);
            else if (bi == 27) m_mode = 1;
        end else if (m_mode == 1) begin
            if (bi == 91) begin
                m_p[0] = 0; m_p[1] = 0; m_idx = 0; m_mode = 2;
            end else if (bi != 27) m_mode = 0;
        end else begin
            if (bi >= 48 && bi <= 57) m_p[m_idx] = imin(m_p[m_idx] * 10 + (bi - 48), 255);
            else if (bi == 59) m_idx = 1;
            else if (bi == 27) m_mode = 1;
            else begin
                m_mode = 0;
                n = (m_p[0] == 0) ? 1 : m_p[0];
                case (bi)
                    65: m_row = imax(m_row - n, 0);
                    66: m_row = imin(m_row + n, ROWS - 1);
                    67: m_col = imin(m_col + n, COLS - 1);
                    68: m_col = imax(m_col - n, 0);
                    72, 102: begin
                        m_row = imin(imax(m_p[0], 1) - 1, ROWS - 1);
                        m_col = imin(imax(m_p[1], 1) - 1, COLS - 1);
                    end
                    74: if (m_p[0] == 2) begin
                        for (int i = 0; i < CELLS; i++) exp_q.push_back('{i, 32});
                        m_row = 0; m_col = 0; clr = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Waits out a clear already started; optionally pokes a byte mid-clear.
    task automatic wait_clear(input bit inject);
        int ovr0;
        busy_cycles = 0;
        ovr0 = ovr_seen;
        for (int k = 0; k < CELLS + 20 && o_busy; k++) begin
            if (inject && k == 100) begin
                @(negedge clk);
                i_byte = 8'h5A;
                i_byte_v = 1'b1;
            end
            @(posedge clk);
            #1 i_byte_v = 1'b0;
        end
        check("busy_deasserted", int'(o_busy), 0);
        check("busy_cycles", busy_cycles, CELLS);
        check("overrun_pulses", ovr_seen - ovr0, inject ? 1 : 0);
        @(posedge clk);
        #1;
        check("clear_writes_drained", exp_q.size(), 0);
        check("cursor_after_clear", int'(o_cursor), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit inject = 1'b0);
        bit clr;
        model_byte(b, clr);
        @(negedge clk);
        i_byte = b;
        i_byte_v = 1'b1;
        @(posedge clk);
        #1 i_byte_v = 1'b0;
        if (clr) wait_clear(inject);
        else begin
            @(posedge clk);
            #1 check("cursor", int'(o_cursor), m_row * COLS + m_col);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_csi(input string s);
        send_byte(8'h1B);
        send_str({"[", s});
    endtask

    initial begin
        string fin;
        bit    dummy;
        int    r;
        fin = "ABCDHfJxm";
        model_reset();

        #12;
        check("reset_outputs", int'({o_wen, o_addr, o_wdata, o_cursor, o_busy, o_overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        send_str("Hi");
        check("hi_cursor", int'(o_cursor), 2);

        send_csi("5;10H");
        send_byte("X");
        check("cup_cursor", int'(o_cursor), 170);

        send_csi("H");
        send_csi("99A");
        check("up_clamp_cursor", int'(o_cursor), 0);
        send_csi("300B");
        send_csi("0C");
        check("clamp_cursor", int'(o_cursor), 961);

        send_csi("2");
        send_byte("J", 1'b1);

        for (int i = 0; i < 41; i++) send_byte(8'(8'h61 + (i % 26)));
`ifdef TERM_DECODER_AUTOWRAP_EN
        check("row_end_cursor", int'(o_cursor), 41);
`else
        check("row_end_cursor", int'(o_cursor), 39);
`endif

        send_csi("3x");
        send_byte(8'h1B);
        send_byte("Q");
        send_csi("1;6H");
        check("col5_cursor", int'(o_cursor), 5);
        send_byte(8'h0D);
        check("cr_cursor", int'(o_cursor), 0);
        send_byte(8'h0A);
        check("lf_cursor", int'(o_cursor), 40);
        send_byte(8'h08);
        check("bs_cursor", int'(o_cursor), 40);
        check("abort_no_writes", exp_q.size(), 0);

        // Randomized mix of text, controls, raw bytes and CSI sequences.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45) send_byte(8'($urandom_range(32, 126)));
            else if (r < 55) begin
                case ($urandom_range(0, 2))
                    0: send_byte(8'h0D);
                    1: send_byte(8'h0A);
                    default: send_byte(8'h08);
                endcase
            end else if (r < 70) send_byte(8'($urandom_range(0, 255)));
            else begin
                send_byte(8'h1B);
                send_byte("[");
                repeat ($urandom_range(0, 3)) send_byte(8'(8'h30 + $urandom_range(0, 9)));
                if ($urandom_range(0, 1) == 1) begin
                    send_byte(";");
                    repeat ($urandom_range(0, 3)) send_byte(8'(8'h30 + $urandom_range(0, 9)));
                end
                send_byte(fin[$urandom_range(0, fin.len() - 1)]);
            end
        end
        check("random_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a CSI sequence.
        send_csi("3");
        #3 rst_n = 1'b0;
        #1 check("reset_mid_csi", int'({o_wen, o_addr, o_wdata, o_cursor, o_busy, o_overrun}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_byte("5");
        check("after_reset_cursor", int'(o_cursor), 1);

        // Asynchronous reset in the middle of a clear abandons it.
        send_byte(8'h1B);
        send_str("[2");
        model_byte("J", dummy);
        @(negedge clk);
        i_byte = "J";
        i_byte_v = 1'b1;
        @(posedge clk);
        #1 i_byte_v = 1'b0;
        repeat (50) @(posedge clk);
        #2 check("busy_mid_clear", int'(o_busy), 1);
        rst_n = 1'b0;
        #1 check("reset_mid_clear", int'({o_wen, o_addr, o_wdata, o_cursor, o_busy, o_overrun}), 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("clear_abandoned", int'({o_busy, o_wen}), 0);
        send_byte("Z");
        check("post_clear_reset_cursor", int'(o_cursor), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
